// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared encodings and defaults for the DMEM arbiter
// Holds the arbiter FSM states, read-owner tags and default bus widths.
package dmem_arbiter_pkg;

    localparam int DMEM_ADDR_W  = 14;
    localparam int DMEM_DATA_W  = 32;
    localparam int STARVE_CNT_W = 4;

    typedef enum logic {
        ARB_CORE       = 1'b0,
        ARB_ACC_FORCED = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        RD_OWNER_NONE = 2'd0,
        RD_OWNER_CORE = 2'd1,
        RD_OWNER_ACC  = 2'd2
    } rd_owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - bus bundle between core, accelerator, arbiter and DMEM
// slave modport: arbiter view (requests and dmem_dout in, grants/DMEM drive out).
// master modport: environment view (core, accelerator and DMEM block RAM).
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) ();

    logic              core_en;
    logic [3:0]        core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_din;
    logic              core_stall;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_dout;

    logic              acc_valid;
    logic              acc_ready;
    logic [3:0]        acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_din;
    logic              acc_rvalid;
    logic [DATA_W-1:0] acc_rdata;

    logic              dmem_en;
    logic [3:0]        dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_din;
    logic [DATA_W-1:0] dmem_dout;

    modport slave (
        input  core_en, core_we, core_addr, core_din,
        output core_stall, core_rvalid, core_dout,
        input  acc_valid, acc_we, acc_addr, acc_din,
        output acc_ready, acc_rvalid, acc_rdata,
        output dmem_en, dmem_we, dmem_addr, dmem_din,
        input  dmem_dout
    );

    modport master (
        output core_en, core_we, core_addr, core_din,
        input  core_stall, core_rvalid, core_dout,
        output acc_valid, acc_we, acc_addr, acc_din,
        input  acc_ready, acc_rvalid, acc_rdata,
        input  dmem_en, dmem_we, dmem_addr, dmem_din,
        output dmem_dout
    );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// rtl/dmem_arbiter_starve_counter.sv - saturating accelerator starvation counter
// Ports: clk, rst (sync, active-high), inc, clr, cnt (count), limit_hit (cnt at LIMIT-1).
module dmem_starve_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inc,
    input  logic                    clr,
    output logic [STARVE_CNT_W-1:0] cnt,
    output logic                    limit_hit
);

    localparam logic [STARVE_CNT_W-1:0] TOP = STARVE_CNT_W'(LIMIT - 1);

    assign limit_hit = (cnt == TOP);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !limit_hit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/accelerator arbiter for the single-port DMEM
// Ports: clk, rst (sync, active-high), bus (dmem_arbiter_if.slave) carrying the
// core request/stall/read-return, accelerator valid/ready/read-return and DMEM drive.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int DATA_W       = DMEM_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    arb_state_t              state;
    arb_state_t              state_nxt;
    rd_owner_t               rd_owner;
    logic                    grant_core;
    logic                    grant_acc;
    logic                    starve_inc;
    logic                    limit_hit;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic [3:0]              mux_we;
    logic [ADDR_W-1:0]       mux_addr;
    logic [DATA_W-1:0]       mux_din;

    // The accelerator wins when the core is idle, or in the forced slot while it
    // still requests; a withdrawn forced slot falls back to the core.
    always_comb begin
        grant_acc  = bus.acc_valid && ((state == ARB_ACC_FORCED) || !bus.core_en);
        grant_core = bus.core_en && !grant_acc;
        starve_inc = bus.acc_valid && !grant_acc;
        state_nxt  = ARB_CORE;
        if ((state == ARB_CORE) && starve_inc && limit_hit) begin
            state_nxt = ARB_ACC_FORCED;
        end
    end

    always_comb begin
        mux_we   = '0;
        mux_addr = '0;
        mux_din  = '0;
        if (grant_core) begin
            mux_we   = bus.core_we;
            mux_addr = bus.core_addr;
            mux_din  = bus.core_din;
        end else if (grant_acc) begin
            mux_we   = bus.acc_we;
            mux_addr = bus.acc_addr;
            mux_din  = bus.acc_din;
        end
    end

    always_comb begin
        bus.dmem_en     = grant_core || grant_acc;
        bus.dmem_we     = mux_we;
        bus.dmem_addr   = mux_addr;
        bus.dmem_din    = mux_din;
        bus.core_stall  = bus.core_en && !grant_core;
        bus.acc_ready   = grant_acc;
        bus.core_rvalid = (rd_owner == RD_OWNER_CORE);
        bus.acc_rvalid  = (rd_owner == RD_OWNER_ACC);
        bus.core_dout   = bus.dmem_dout;
        bus.acc_rdata   = bus.dmem_dout;
    end

    // rd_owner tags whoever issued this cycle's read so the block RAM's
    // 1-cycle-late data is steered back to it; a reset drops the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_CORE;
            rd_owner <= RD_OWNER_NONE;
        end else begin
            state <= state_nxt;
            if (grant_core && (bus.core_we == 4'd0)) begin
                rd_owner <= RD_OWNER_CORE;
            end else if (grant_acc && (bus.acc_we == 4'd0)) begin
                rd_owner <= RD_OWNER_ACC;
            end else begin
                rd_owner <= RD_OWNER_NONE;
            end
        end
    end

    dmem_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .inc       (starve_inc),
        .clr       (!starve_inc),
        .cnt       (starve_cnt),
        .limit_hit (limit_hit)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Block RAM stand-in: 1-cycle synchronous read, read-first, byte writes.
    logic [DW-1:0] env_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.dmem_en) begin
            bus.dmem_dout <= env_mem[bus.dmem_addr];
            for (int b = 0; b < 4; b++) begin
                if (bus.dmem_we[b]) env_mem[bus.dmem_addr][b*8 +: 8] <= bus.dmem_din[b*8 +: 8];
            end
        end
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            loss_run = 0;  // consecutive cycles the accelerator asked and lost
    int            pend = 0;      // 0 none, 1 core, 2 acc: read issued last cycle
    logic [DW-1:0] pend_data = '0;
    int            tests = 0;
    int            fails = 0;
    logic          obs_core_stall, obs_acc_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_core(input logic en, input logic [3:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.core_en = en; bus.core_we = we; bus.core_addr = a; bus.core_din = d;
    endtask

    task automatic set_acc(input logic v, input logic [3:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.acc_valid = v; bus.acc_we = we; bus.acc_addr = a; bus.acc_din = d;
    endtask

    // One clock: compare at negedge against the model, then advance the model.
    task automatic step(input logic rst_v);
        logic          forced, e_acc, e_core;
        logic [3:0]    we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            owner;
        int            new_pend;
        logic [DW-1:0] new_data;
        rst = rst_v;
        @(negedge clk);
        forced = (loss_run >= LIMIT);
        e_acc  = bus.acc_valid && (forced || !bus.core_en);
        e_core = bus.core_en && !e_acc;
        owner = 0; we = '0; a = '0; d = '0;
        if (e_core) begin owner = 1; we = bus.core_we; a = bus.core_addr; d = bus.core_din; end
        else if (e_acc) begin owner = 2; we = bus.acc_we; a = bus.acc_addr; d = bus.acc_din; end
        obs_core_stall = bus.core_stall;
        obs_acc_ready  = bus.acc_ready;
        if (!rst_v) begin
            chk("core_stall", 64'(bus.core_stall), 64'(bus.core_en && !e_core));
            chk("acc_ready", 64'(bus.acc_ready), 64'(e_acc));
            chk("dmem_en", 64'(bus.dmem_en), 64'(owner != 0));
            chk("dmem_we", 64'(bus.dmem_we), 64'(we));
            if (owner != 0) begin
                chk("dmem_addr", 64'(bus.dmem_addr), 64'(a));
                chk("dmem_din", 64'(bus.dmem_din), 64'(d));
            end
            chk("core_rvalid", 64'(bus.core_rvalid), 64'(pend == 1));
            chk("acc_rvalid", 64'(bus.acc_rvalid), 64'(pend == 2));
            if (pend == 1) chk("core_dout", 64'(bus.core_dout), 64'(pend_data));
            if (pend == 2) chk("acc_rdata", 64'(bus.acc_rdata), 64'(pend_data));
        end
        new_pend = 0; new_data = '0;
        if (owner != 0 && we == 4'd0) begin new_pend = owner; new_data = ref_mem[a]; end
        if (owner != 0) begin
            for (int b = 0; b < 4; b++) if (we[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
        end
        if (rst_v) begin
            loss_run = 0; pend = 0;
        end else begin
            loss_run  = (bus.acc_valid && !e_acc) ? loss_run + 1 : 0;
            pend      = new_pend;
            pend_data = new_data;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_core(1'b0, 4'd0, '0, '0);
        set_acc(1'b0, 4'd0, '0, '0);
        step(1'b1);
        step(1'b1);
        set_core(1'b1, 4'd0, 14'h10, '0);
        step(1'b0);
        set_core(1'b0, 4'd0, '0, '0);
        // Reset state, checked on the first clean cycle.
        chk("rst_state", 64'(dut.state), 64'(ARB_CORE));
        chk("rst_starve", 64'(dut.starve_cnt), 64'd0);
        chk("rst_core_rvalid", 64'(bus.core_rvalid), 64'd1);  // read issued just above
        step(1'b1);
        chk("rst_drop_core_rvalid", 64'(bus.core_rvalid), 64'd0);
        chk("rst_acc_rvalid", 64'(bus.acc_rvalid), 64'd0);

        // Initialise addresses used by random traffic.
        for (int i = 0; i < 16; i++) begin
            set_core(1'b1, 4'hF, AW'(i), $urandom);
            step(1'b0);
        end
        set_core(1'b1, 4'hF, 14'h10, 32'hDEADBEEF); step(1'b0);
        set_core(1'b1, 4'hF, 14'h01, 32'hA5A50001); step(1'b0);
        set_core(1'b1, 4'hF, 14'h02, 32'h5A5A0002); step(1'b0);

        // Core-only read.
        set_core(1'b1, 4'd0, 14'h10, '0); step(1'b0);
        chk("core_only_stall", 64'(obs_core_stall), 64'd0);
        chk("core_only_rvalid", 64'(bus.core_rvalid), 64'd1);
        chk("core_only_dout", 64'(bus.core_dout), 64'hDEADBEEF);
        chk("core_only_acc_rvalid", 64'(bus.acc_rvalid), 64'd0);
        set_core(1'b0, 4'd0, '0, '0);

        // Accelerator-only write then read.
        set_acc(1'b1, 4'hF, 14'h20, 32'h12345678); step(1'b0);
        chk("acc_wr_ready", 64'(obs_acc_ready), 64'd1);
        set_acc(1'b1, 4'd0, 14'h20, '0); step(1'b0);
        chk("acc_rd_ready", 64'(obs_acc_ready), 64'd1);
        chk("acc_rvalid", 64'(bus.acc_rvalid), 64'd1);
        chk("acc_rdata", 64'(bus.acc_rdata), 64'h12345678);
        set_acc(1'b0, 4'd0, '0, '0); step(1'b0);

        // Continuous contention: forced accelerator slot every fifth cycle.
        for (int k = 1; k <= 15; k++) begin
            set_core(1'b1, 4'd0, AW'($urandom_range(0, 15)), '0);
            set_acc(1'b1, 4'd0, AW'($urandom_range(0, 15)), '0);
            step(1'b0);
            chk($sformatf("contend_ready_%0d", k), 64'(obs_acc_ready), 64'(k % 5 == 0));
            chk($sformatf("contend_stall_%0d", k), 64'(obs_core_stall), 64'(k % 5 == 0));
        end

        // Accelerator withdraws during the forced slot.
        for (int k = 1; k <= 4; k++) step(1'b0);
        chk("forced_state", 64'(dut.state), 64'(ARB_ACC_FORCED));
        set_acc(1'b0, 4'd0, '0, '0); step(1'b0);
        chk("withdraw_stall", 64'(obs_core_stall), 64'd0);
        chk("withdraw_state", 64'(dut.state), 64'(ARB_CORE));
        chk("withdraw_starve", 64'(dut.starve_cnt), 64'd0);

        // Reset mid-read after some starvation has built up.
        set_acc(1'b1, 4'd0, 14'h3, '0);
        step(1'b0); step(1'b0);
        set_core(1'b1, 4'd0, 14'h10, '0);
        step(1'b1);
        chk("rstmid_core_rvalid", 64'(bus.core_rvalid), 64'd0);
        chk("rstmid_state", 64'(dut.state), 64'(ARB_CORE));
        chk("rstmid_starve", 64'(dut.starve_cnt), 64'd0);
        set_core(1'b0, 4'd0, '0, '0);
        set_acc(1'b0, 4'd0, '0, '0);
        step(1'b0);

        // Interleaved reads.
        set_core(1'b1, 4'd0, 14'h01, '0); step(1'b0);
        chk("il_core_rvalid", 64'(bus.core_rvalid), 64'd1);
        chk("il_core_dout", 64'(bus.core_dout), 64'hA5A50001);
        chk("il_acc_rvalid0", 64'(bus.acc_rvalid), 64'd0);
        set_core(1'b0, 4'd0, '0, '0);
        set_acc(1'b1, 4'd0, 14'h02, '0); step(1'b0);
        chk("il_acc_rvalid", 64'(bus.acc_rvalid), 64'd1);
        chk("il_acc_rdata", 64'(bus.acc_rdata), 64'h5A5A0002);
        chk("il_core_rvalid0", 64'(bus.core_rvalid), 64'd0);

        // Randomized traffic; a stalled core holds its request.
        for (int n = 0; n < 3000; n++) begin
            if (!obs_core_stall) begin
                set_core($urandom_range(0, 9) < 6,
                         ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                         AW'($urandom_range(0, 15)), $urandom);
            end
            set_acc($urandom_range(0, 9) < 6,
                    ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                    AW'($urandom_range(0, 15)), $urandom);
            step($urandom_range(0, 99) == 0);
            if (rst) obs_core_stall = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
